// File: rtl/dual_port_ram_arbiter_if.sv
// Requester-side bus of dual_port_ram_arbiter.
// All per-requester fields are packed, requester i in slice i.
//   req_valid      request valid, one bit per requester
//   req_ready      grant; a transfer happens when valid & ready in the same cycle
//   req_write      1 = write, 0 = read
//   req_address    packed addresses, requester i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   req_writeData  packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid     one-cycle read-data pulse per requester
//   resp_readData  packed read data, valid lane only while its resp_valid is high
// master: the requesters (or a bench acting for them); slave: the arbiter.
interface dual_port_ram_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_REQ       = 4
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               req_write;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_writeData;
  logic [NUM_REQ-1:0]               resp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0]    resp_readData;

  modport master (
    output req_valid, req_write, req_address, req_writeData,
    input  req_ready, resp_valid, resp_readData
  );

  modport slave (
    input  req_valid, req_write, req_address, req_writeData,
    output req_ready, resp_valid, resp_readData
  );
endinterface

// File: rtl/dual_port_ram_arbiter.sv
// Shares one dual-port RAM (synchronous read, 1-cycle latency) among NUM_REQ
// requesters. Up to two requests are granted per cycle, round-robin, one per
// RAM port; read data returns one cycle after the grant. After reset the RAM
// can be zeroed two words per cycle before traffic is accepted.
// Ports:
//   clock               clock
//   reset               asynchronous, active-low reset
//   bus                 requester bus (slave side), see dual_port_ram_arbiter_if
//   init_done           1 once serving requests
//   writeEnable_0/1     RAM write enables
//   address_0/1         RAM addresses
//   writeData_0/1       RAM write data
//   readData_0/1        RAM read data, valid the cycle after the address
//
// state    | meaning
// ST_CLEAR | zeroing RAM, word pair {2k, 2k+1} per cycle, no grants
// ST_SERVE | round-robin arbitration of requests onto both RAM ports
module dual_port_ram_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int NUM_REQ        = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  dual_port_ram_arbiter_if.slave   bus,
  output logic                     init_done,
  output logic                     writeEnable_0,
  output logic [ADDRESS_WIDTH-1:0] address_0,
  output logic [DATA_WIDTH-1:0]    writeData_0,
  input  logic [DATA_WIDTH-1:0]    readData_0,
  output logic                     writeEnable_1,
  output logic [ADDRESS_WIDTH-1:0] address_1,
  output logic [DATA_WIDTH-1:0]    writeData_1,
  input  logic [DATA_WIDTH-1:0]    readData_1
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = ADDRESS_WIDTH - 1;
  localparam logic [CW-1:0] CLEAR_LAST = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

  state_t          state_q, state_d;
  logic [CW-1:0]   clear_cnt_q, clear_cnt_d;
  logic            init_done_q, init_done_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [1:0]      rd_valid_q, rd_valid_d;
  logic [IW-1:0]   rd_id0_q, rd_id0_d;
  logic [IW-1:0]   rd_id1_q, rd_id1_d;

  logic [NUM_REQ-1:0]       req_valid_w;
  logic [NUM_REQ-1:0]       req_write_w;
  logic [ADDRESS_WIDTH-1:0] req_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    req_wdata [NUM_REQ];

  assign req_valid_w = bus.req_valid;
  assign req_write_w = bus.req_write;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_addr[gi]  = bus.req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign req_wdata[gi] = bus.req_writeData[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    if (int'(v) == NUM_REQ - 1) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // Round-robin scan from ptr_q: first valid requester -> port 0,
  // second valid requester -> port 1 candidate.
  logic          g0_found, g1_found, g1_issue;
  logic [IW-1:0] g0_idx, g1_idx, cand;

  always_comb begin
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    cand     = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      cand = IW'((int'(ptr_q) + o) % NUM_REQ);
      if (req_valid_w[cand]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = cand;
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = cand;
        end
      end
    end
  end

  // Same address with a write on either side would make the port order
  // matter, so only the port-0 grant issues; the other retries next cycle.
  always_comb begin
    g1_issue = g1_found;
    if (g1_found && (req_addr[g0_idx] == req_addr[g1_idx]) &&
        (req_write_w[g0_idx] || req_write_w[g1_idx])) begin
      g1_issue = 1'b0;
    end
  end

  // RAM port drive and grants. Everything is masked while reset is low so
  // the outputs are quiet even when the reset state is ST_SERVE.
  logic [NUM_REQ-1:0]       ready_w;
  logic                     we0_w, we1_w;
  logic [ADDRESS_WIDTH-1:0] a0_w, a1_w;
  logic [DATA_WIDTH-1:0]    wd0_w, wd1_w;

  always_comb begin
    ready_w = '0;
    we0_w   = 1'b0;
    we1_w   = 1'b0;
    a0_w    = '0;
    a1_w    = '0;
    wd0_w   = '0;
    wd1_w   = '0;
    if (state_q == ST_CLEAR) begin
      we0_w = 1'b1;
      we1_w = 1'b1;
      a0_w  = {clear_cnt_q, 1'b0};
      a1_w  = {clear_cnt_q, 1'b1};
    end else begin
      if (g0_found) begin
        ready_w[g0_idx] = 1'b1;
        we0_w           = req_write_w[g0_idx];
        a0_w            = req_addr[g0_idx];
        wd0_w           = req_write_w[g0_idx] ? req_wdata[g0_idx] : '0;
      end
      if (g1_issue) begin
        ready_w[g1_idx] = 1'b1;
        we1_w           = req_write_w[g1_idx];
        a1_w            = req_addr[g1_idx];
        wd1_w           = req_write_w[g1_idx] ? req_wdata[g1_idx] : '0;
      end
    end
  end

  assign bus.req_ready  = ready_w & {NUM_REQ{reset}};
  assign writeEnable_0  = we0_w & reset;
  assign writeEnable_1  = we1_w & reset;
  assign address_0      = a0_w & {ADDRESS_WIDTH{reset}};
  assign address_1      = a1_w & {ADDRESS_WIDTH{reset}};
  assign writeData_0    = wd0_w & {DATA_WIDTH{reset}};
  assign writeData_1    = wd1_w & {DATA_WIDTH{reset}};
  assign init_done      = init_done_q & reset;

  // Read responses: the registered port/ID pair routes each RAM read port
  // to its requester lane in the cycle the RAM presents the data.
  logic [NUM_REQ-1:0]            resp_valid_w;
  logic [NUM_REQ*DATA_WIDTH-1:0] resp_data_w;

  always_comb begin
    resp_valid_w = '0;
    resp_data_w  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_valid_q[0] && (rd_id0_q == IW'(i))) begin
        resp_valid_w[i]                      = 1'b1;
        resp_data_w[i*DATA_WIDTH +: DATA_WIDTH] = readData_0;
      end
      if (rd_valid_q[1] && (rd_id1_q == IW'(i))) begin
        resp_valid_w[i]                      = 1'b1;
        resp_data_w[i*DATA_WIDTH +: DATA_WIDTH] = readData_1;
      end
    end
  end

  assign bus.resp_valid    = resp_valid_w;
  assign bus.resp_readData = resp_data_w;

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    init_done_d = init_done_q;
    ptr_d       = ptr_q;
    rd_valid_d  = '0;
    rd_id0_d    = '0;
    rd_id1_d    = '0;
    if (state_q == ST_CLEAR) begin
      clear_cnt_d = clear_cnt_q + 1'b1;
      if (clear_cnt_q == CLEAR_LAST) begin
        state_d     = ST_SERVE;
        init_done_d = 1'b1;
      end
    end else begin
      if (g0_found) begin
        rd_valid_d[0] = !req_write_w[g0_idx];
        rd_id0_d      = g0_idx;
        ptr_d         = inc_mod(g0_idx);
      end
      if (g1_issue) begin
        rd_valid_d[1] = !req_write_w[g1_idx];
        rd_id1_d      = g1_idx;
        ptr_d         = inc_mod(g1_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      clear_cnt_q <= '0;
      init_done_q <= !CLEAR_ON_RESET;
      ptr_q       <= '0;
      rd_valid_q  <= '0;
      rd_id0_q    <= '0;
      rd_id1_q    <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      init_done_q <= init_done_d;
      ptr_q       <= ptr_d;
      rd_valid_q  <= rd_valid_d;
      rd_id0_q    <= rd_id0_d;
      rd_id1_q    <= rd_id1_d;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
`timescale 1ns/1ps
module tb_dual_port_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          init_done;
  logic          we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] wd0, wd1;
  logic [DW-1:0] rd0, rd1;
  logic          preload;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt [NR];
  logic resp_seen;

  dual_port_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(NR)) bus();

  dual_port_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(NR), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .init_done(init_done),
    .writeEnable_0(we0),
    .address_0(a0),
    .writeData_0(wd0),
    .readData_0(rd0),
    .writeEnable_1(we1),
    .address_1(a1),
    .writeData_1(wd1),
    .readData_1(rd1)
  );

  always #5 clock = ~clock;

  // Behavioural dual-port RAM, synchronous read; preloaded with 8'hA5 so the
  // clear pass is observable.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= 8'hA5;
    end else begin
      if (we0) mem[a0] <= wd0;
      if (we1) mem[a1] <= wd1;
    end
    rd0 <= mem[a0];
    rd1 <= mem[a1];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]               = v;
    bus.req_write[i]               = w;
    bus.req_address[i*AW +: AW]    = a;
    bus.req_writeData[i*DW +: DW]  = d;
  endtask

  function automatic logic [DW-1:0] lane(input int i);
    return bus.resp_readData[i*DW +: DW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid     = '0;
    bus.req_write     = '0;
    bus.req_address   = '0;
    bus.req_writeData = '0;
    preload = 1'b1;
    reset   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    preload = 1'b0;

    // Reset: all outputs quiet even with every request valid.
    bus.req_valid = '1;
    #1;
    chk4("rst_ready", bus.req_ready, 4'b0000);
    chk1("rst_we0", we0, 1'b0);
    chk1("rst_we1", we1, 1'b0);
    chk1("rst_init_done", init_done, 1'b0);
    chk4("rst_resp_valid", bus.resp_valid, 4'b0000);

    // Clear pass: 8 cycles, no grants, word pair {2k,2k+1} per cycle.
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
      if (n == 1) begin
        chk4("clear_ready", bus.req_ready, 4'b0000);
        chk1("clear_we0", we0, 1'b1);
        chk4("clear_a0", a0, 4'd2);
        chk4("clear_a1", a1, 4'd3);
        chk8("clear_wd1", wd1, 8'h00);
        bus.req_valid = '0;
      end
    end
    chki("clear_cycles", n, 8);

    // Read back the whole RAM, two addresses per step.
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      set_req(0, 1'b1, 1'b0, AW'(2*j), 8'h00);
      set_req(1, 1'b1, 1'b0, AW'(2*j+1), 8'h00);
      #1;
      chk4("clr_rd_ready", bus.req_ready, 4'b0011);
      @(negedge clock);
      bus.req_valid = '0;
      #1;
      chk4("clr_rd_resp_valid", bus.resp_valid, 4'b0011);
      chk8("clr_rd_even", lane(0), 8'h00);
      chk8("clr_rd_odd", lane(1), 8'h00);
    end

    // req0 write then read back addr 14.
    @(negedge clock);
    set_req(0, 1'b1, 1'b1, 4'd14, 8'h49);
    #1;
    chk4("wr_ready", bus.req_ready, 4'b0001);
    chk1("wr_we0", we0, 1'b1);
    chk4("wr_a0", a0, 4'd14);
    chk8("wr_wd0", wd0, 8'h49);
    chk1("wr_we1_idle", we1, 1'b0);
    chk4("wr_a1_idle", a1, 4'd0);
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 4'd14, 8'h00);
    #1;
    chk4("rd_ready", bus.req_ready, 4'b0001);
    chk1("rd_we0", we0, 1'b0);
    chk4("wr_no_resp", bus.resp_valid, 4'b0000);
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    chk4("rd_resp_valid", bus.resp_valid, 4'b0001);
    chk8("rd_resp_data", lane(0), 8'h49);

    // Two writes in one cycle (pointer is 1, so req2 on port 0, req3 on port 1).
    @(negedge clock);
    set_req(2, 1'b1, 1'b1, 4'd3, 8'h3C);
    set_req(3, 1'b1, 1'b1, 4'd7, 8'h7E);
    #1;
    chk4("dual_wr_ready", bus.req_ready, 4'b1100);
    chk4("dual_wr_a0", a0, 4'd3);
    chk8("dual_wr_wd1", wd1, 8'h7E);

    // Four reads at once from pointer 0: {0,1} then {2,3}.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 4'd14, 8'h00);
    set_req(1, 1'b1, 1'b0, 4'd7,  8'h00);
    set_req(2, 1'b1, 1'b0, 4'd3,  8'h00);
    set_req(3, 1'b1, 1'b0, 4'd15, 8'h00);
    #1;
    chk4("rr4_ready_a", bus.req_ready, 4'b0011);
    chk4("rr4_a0_a", a0, 4'd14);
    chk4("rr4_a1_a", a1, 4'd7);
    @(negedge clock);
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b0;
    #1;
    chk4("rr4_ready_b", bus.req_ready, 4'b1100);
    chk4("rr4_a0_b", a0, 4'd3);
    chk4("rr4_a1_b", a1, 4'd15);
    chk4("rr4_resp_a", bus.resp_valid, 4'b0011);
    chk8("rr4_d0", lane(0), 8'h49);
    chk8("rr4_d1", lane(1), 8'h7E);
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    chk4("rr4_resp_b", bus.resp_valid, 4'b1100);
    chk8("rr4_d2", lane(2), 8'h3C);
    chk8("rr4_d3", lane(3), 8'h00);

    // Write/read conflict on addr 5: only req1 (port 0) granted.
    @(negedge clock);
    set_req(1, 1'b1, 1'b1, 4'd5, 8'h53);
    set_req(2, 1'b1, 1'b0, 4'd5, 8'h00);
    #1;
    chk4("conf_ready", bus.req_ready, 4'b0010);
    chk1("conf_we0", we0, 1'b1);
    chk4("conf_a0", a0, 4'd5);
    chk1("conf_we1", we1, 1'b0);
    chk4("conf_a1", a1, 4'd0);
    @(negedge clock);
    bus.req_valid[1] = 1'b0;
    #1;
    chk4("conf_retry_ready", bus.req_ready, 4'b0100);
    chk1("conf_retry_we0", we0, 1'b0);
    chk4("conf_retry_a0", a0, 4'd5);
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    chk4("conf_resp_valid", bus.resp_valid, 4'b0100);
    chk8("conf_resp_data", lane(2), 8'h53);
    chk8("conf_other_lane", lane(0), 8'h00);

    // Fairness: three requesters valid for 12 cycles -> 24 grants, 8 each.
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
    set_req(3, 1'b1, 1'b0, 4'd4, 8'h00);
    for (int c = 0; c < 12; c++) begin
      #1;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i]) cnt[i]++;
      end
      @(negedge clock);
    end
    bus.req_valid = '0;
    chki("fair_req0", cnt[0], 8);
    chki("fair_req1", cnt[1], 8);
    chki("fair_req2_idle", cnt[2], 0);
    chki("fair_req3", cnt[3], 8);

    // Reset in the cycle after a read grant: the response is dropped.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 4'd14, 8'h00);
    #1;
    chk4("rstrd_ready", bus.req_ready, 4'b0001);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.req_valid = '0;
    #1;
    chk4("rstrd_resp_dropped", bus.resp_valid, 4'b0000);
    chk1("rstrd_init_low", init_done, 1'b0);
    resp_seen = 1'b0;
    repeat (2) begin
      @(negedge clock);
      resp_seen = resp_seen | (|bus.resp_valid);
    end
    reset = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
      resp_seen = resp_seen | (|bus.resp_valid);
    end
    chki("reclear_cycles", n, 8);
    chk1("reclear_no_resp", resp_seen, 1'b0);

    // Clear rerun wiped addr 14.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 4'd14, 8'h00);
    #1;
    chk4("post_ready", bus.req_ready, 4'b0001);
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    chk4("post_resp_valid", bus.resp_valid, 4'b0001);
    chk8("post_resp_data", lane(0), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
